// File: rtl/bbox_outline_writer_if.sv
// bbox_outline_writer_if: draw request plus image-RAM write port bundle for the outline writer
interface bbox_outline_writer_if #(
  parameter int xSz    = 6,
  parameter int ySz    = 6,
  parameter int addrSz = 12,
  parameter int colSz  = 3
);
  logic              start;
  logic [ySz-1:0]    mostTop;
  logic [ySz-1:0]    mostBottom;
  logic [xSz-1:0]    mostLeft;
  logic [xSz-1:0]    mostRight;
  logic [colSz-1:0]  colour;
  logic [addrSz-1:0] mem_address;
  logic [colSz-1:0]  mem_data;
  logic              mem_wren;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, mostTop, mostBottom, mostLeft, mostRight, colour,
    input  mem_address, mem_data, mem_wren, busy, done, err
  );
  modport slave (
    input  start, mostTop, mostBottom, mostLeft, mostRight, colour,
    output mem_address, mem_data, mem_wren, busy, done, err
  );
endinterface

// File: rtl/bbox_outline_writer.sv
// bbox_outline_writer: draws a one-pixel rectangle outline into the image RAM, one pixel per clock
module bbox_outline_writer #(
  parameter int X_RES  = 60,
  parameter int Y_RES  = 60,
  parameter int xSz    = 6,
  parameter int ySz    = 6,
  parameter int addrSz = 12,
  parameter int colSz  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  bbox_outline_writer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE} state_t;
  state_t           state_q, state_d;
  logic [xSz-1:0]   x_q, x_d, l_q, l_d, r_q, r_d;
  logic [ySz-1:0]   y_q, y_d, t_q, t_d, b_q, b_d;
  logic [colSz-1:0] col_q, col_d;
  logic             err_q, err_d, bad, wr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      b_q     <= '0;
      l_q     <= '0;
      r_q     <= '0;
      col_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
      b_q     <= b_d;
      l_q     <= l_d;
      r_q     <= r_d;
      col_q   <= col_d;
      err_q   <= err_d;
    end
  end
  // Edges are walked TOP, BOTTOM, then the interior rows of LEFT and RIGHT so corners are written once
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    b_d     = b_q;
    l_d     = l_q;
    r_d     = r_q;
    col_d   = col_q;
    err_d   = err_q;
    bad     = bus.mostLeft > bus.mostRight || bus.mostTop > bus.mostBottom ||
              int'(bus.mostRight) >= X_RES || int'(bus.mostBottom) >= Y_RES;
    case (state_q)
      IDLE: if (bus.start) begin
        t_d     = bus.mostTop;
        b_d     = bus.mostBottom;
        l_d     = bus.mostLeft;
        r_d     = bus.mostRight;
        col_d   = bus.colour;
        err_d   = bad;
        x_d     = bus.mostLeft;
        y_d     = bus.mostTop;
        state_d = bad ? DONE : TOP;
      end
      TOP: if (x_q == r_q) begin
        state_d = b_q > t_q ? BOTTOM : DONE;
        x_d     = l_q;
        y_d     = b_q;
      end else x_d = x_q + 1'b1;
      BOTTOM: if (x_q == r_q) begin
        state_d = b_q - t_q >= ySz'(2) ? LEFT : DONE;
        x_d     = l_q;
        y_d     = t_q + 1'b1;
      end else x_d = x_q + 1'b1;
      LEFT: if (y_q == b_q - 1'b1) begin
        state_d = r_q > l_q ? RIGHT : DONE;
        x_d     = r_q;
        y_d     = t_q + 1'b1;
      end else y_d = y_q + 1'b1;
      RIGHT: if (y_q == b_q - 1'b1) state_d = DONE;
             else y_d = y_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr              = state_q inside {TOP, BOTTOM, LEFT, RIGHT};
    bus.mem_wren    = wr;
    bus.mem_address = wr ? addrSz'(y_q) * addrSz'(X_RES) + addrSz'(x_q) : '0;
    bus.mem_data    = wr ? col_q : '0;
    bus.busy        = state_q != IDLE;
    bus.done        = state_q == DONE;
    bus.err         = err_q;
  end
endmodule

// File: tb/tb_bbox_outline_writer.sv
// tb_bbox_outline_writer: directed scenarios for the outline writer with hand-computed address lists
module tb_bbox_outline_writer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   addrs[$];
  int   done_at, err_at_done, data_bad, gap_seen, post_done, post_busy, post_err;
  bbox_outline_writer_if bus ();
  bbox_outline_writer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic draw(input logic [5:0] t, input logic [5:0] b, input logic [5:0] l,
                      input logic [5:0] r, input logic [2:0] c, input int poke);
    int ended;
    addrs.delete();
    done_at = -1; err_at_done = -1; data_bad = 0; gap_seen = 0; ended = 0;
    bus.mostTop = t; bus.mostBottom = b; bus.mostLeft = l; bus.mostRight = r; bus.colour = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 400; k++) begin
      if (bus.mem_wren) begin
        addrs.push_back(int'(bus.mem_address));
        if (bus.mem_data !== c) data_bad = 1;
        if (ended != 0) gap_seen = 1;
      end else if (addrs.size() > 0) ended = 1;
      if (bus.done === 1'b1 && done_at < 0) begin
        done_at = k;
        err_at_done = int'(bus.err);
      end
      bus.start    = (k == poke);
      bus.mostLeft = (k == poke) ? 6'd0 : l;
      bus.mostTop  = (k == poke) ? 6'd0 : t;
      @(posedge clk); #1;
      if (done_at >= 0) break;
    end
    bus.start = 1'b0;
    post_done = int'(bus.done);
    post_busy = int'(bus.busy);
    post_err  = int'(bus.err);
  endtask

  function automatic int first_diff(input int e[$]);
    for (int i = 0; i < e.size(); i++)
      if (i >= addrs.size() || addrs[i] !== e[i]) return i;
    return addrs.size() > e.size() ? e.size() : -1;
  endfunction

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  task automatic test_reset();
    bus.start = 1'b0; bus.mostTop = '0; bus.mostBottom = '0; bus.mostLeft = '0; bus.mostRight = '0; bus.colour = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++; if ({bus.mem_wren, bus.busy, bus.done, bus.err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {bus.mem_wren, bus.busy, bus.done, bus.err}); else pass_cnt++;
    tot_cnt++; if (bus.mem_address !== 12'd0 || bus.mem_data !== 3'd0) $display("FAIL reset_bus got addr %0d data %0d want 0 0", bus.mem_address, bus.mem_data); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int e[$] = '{123, 124, 125, 126, 127, 303, 304, 305, 306, 307, 183, 243, 187, 247};
    int d;
    draw(6'd2, 6'd5, 6'd3, 6'd7, 3'd4, -1);
    d = first_diff(e);
    tot_cnt++; if (d !== -1) $display("FAIL basic_seq idx %0d got %0d want %0d", d, at(addrs, d), at(e, d)); else pass_cnt++;
    tot_cnt++; if (data_bad !== 0) $display("FAIL basic_data got wrong colour want 4"); else pass_cnt++;
    tot_cnt++; if (gap_seen !== 0) $display("FAIL basic_gap got gap want back-to-back"); else pass_cnt++;
    tot_cnt++; if (done_at !== 15) $display("FAIL basic_done_at got %0d want 15", done_at); else pass_cnt++;
    tot_cnt++; if (err_at_done !== 0) $display("FAIL basic_err got %0d want 0", err_at_done); else pass_cnt++;
    tot_cnt++; if (post_done !== 0 || post_busy !== 0) $display("FAIL basic_after got done %0d busy %0d want 0 0", post_done, post_busy); else pass_cnt++;
  endtask

  task automatic test_single();
    draw(6'd10, 6'd10, 6'd20, 6'd20, 3'd7, -1);
    tot_cnt++; if (addrs.size() !== 1 || at(addrs, 0) !== 620) $display("FAIL single_write got n %0d addr %0d want 1 620", addrs.size(), at(addrs, 0)); else pass_cnt++;
    tot_cnt++; if (done_at !== 2) $display("FAIL single_done_at got %0d want 2", done_at); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    bit seen[int];
    int dup = 0;
    draw(6'd0, 6'd59, 6'd0, 6'd59, 3'd1, -1);
    foreach (addrs[i]) begin
      if (seen.exists(addrs[i])) dup++;
      seen[addrs[i]] = 1'b1;
    end
    tot_cnt++; if (addrs.size() !== 236) $display("FAIL full_count got %0d want 236", addrs.size()); else pass_cnt++;
    tot_cnt++; if (at(addrs, 0) !== 0 || at(addrs, 235) !== 3539) $display("FAIL full_ends got %0d..%0d want 0..3539", at(addrs, 0), at(addrs, 235)); else pass_cnt++;
    tot_cnt++; if (at(addrs, 60) !== 3540 || at(addrs, 120) !== 60 || at(addrs, 178) !== 119) $display("FAIL full_edges got %0d %0d %0d want 3540 60 119", at(addrs, 60), at(addrs, 120), at(addrs, 178)); else pass_cnt++;
    tot_cnt++; if (dup !== 0) $display("FAIL full_dup got %0d want 0", dup); else pass_cnt++;
    tot_cnt++; if (done_at !== 237) $display("FAIL full_done_at got %0d want 237", done_at); else pass_cnt++;
  endtask

  task automatic test_invalid();
    logic [5:0] v[4][4] = '{'{6'd0, 6'd5, 6'd8, 6'd4}, '{6'd9, 6'd3, 6'd0, 6'd5},
                           '{6'd0, 6'd5, 6'd0, 6'd60}, '{6'd0, 6'd60, 6'd0, 6'd5}};
    for (int i = 0; i < 4; i++) begin
      draw(v[i][0], v[i][1], v[i][2], v[i][3], 3'd2, -1);
      tot_cnt++; if (addrs.size() !== 0 || done_at !== 1) $display("FAIL invalid%0d got n %0d done_at %0d want 0 1", i, addrs.size(), done_at); else pass_cnt++;
      tot_cnt++; if (err_at_done !== 1 || post_err !== 1) $display("FAIL invalid%0d_err got %0d/%0d want 1/1", i, err_at_done, post_err); else pass_cnt++;
    end
    draw(6'd10, 6'd10, 6'd20, 6'd20, 3'd3, -1);
    tot_cnt++; if (post_err !== 0 || addrs.size() !== 1) $display("FAIL invalid_clear got err %0d n %0d want 0 1", post_err, addrs.size()); else pass_cnt++;
  endtask

  task automatic test_degenerate();
    int e1[$] = '{65, 245, 125, 185};
    int e2[$] = '{602, 603, 604, 662, 663, 664};
    int d;
    draw(6'd1, 6'd4, 6'd5, 6'd5, 3'd5, -1);
    d = first_diff(e1);
    tot_cnt++; if (d !== -1 || done_at !== 5) $display("FAIL w1_seq idx %0d got %0d want %0d done_at %0d want 5", d, at(addrs, d), at(e1, d), done_at); else pass_cnt++;
    draw(6'd10, 6'd11, 6'd2, 6'd4, 3'd6, -1);
    d = first_diff(e2);
    tot_cnt++; if (d !== -1 || done_at !== 7) $display("FAIL h2_seq idx %0d got %0d want %0d done_at %0d want 7", d, at(addrs, d), at(e2, d), done_at); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad_cnt = 0;
    bus.mostTop = 6'd2; bus.mostBottom = 6'd5; bus.mostLeft = 6'd3; bus.mostRight = 6'd7; bus.colour = 3'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++; if (bus.mem_wren !== 1'b1 || bus.mem_address !== 12'd125) $display("FAIL mid_third got wren %b addr %0d want 1 125", bus.mem_wren, bus.mem_address); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tot_cnt++; if (bus.mem_wren !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL mid_abort got wren %b busy %b done %b want 0 0 0", bus.mem_wren, bus.busy, bus.done); else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      if (bus.done !== 1'b0 || bus.mem_wren !== 1'b0) bad_cnt++;
      @(posedge clk); #1;
    end
    tot_cnt++; if (bad_cnt !== 0) $display("FAIL mid_quiet got %0d active cycles want 0", bad_cnt); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int e[$] = '{123, 124, 125, 126, 127, 303, 304, 305, 306, 307, 183, 243, 187, 247};
    int d;
    draw(6'd2, 6'd5, 6'd3, 6'd7, 3'd4, 5);
    d = first_diff(e);
    tot_cnt++; if (d !== -1 || done_at !== 15) $display("FAIL busy_start idx %0d got %0d want %0d done_at %0d want 15", d, at(addrs, d), at(e, d), done_at); else pass_cnt++;
    draw(6'd2, 6'd5, 6'd3, 6'd7, 3'd4, 15);
    tot_cnt++; if (post_busy !== 0) $display("FAIL done_start got busy %0d want 0", post_busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_full_frame();
    test_invalid();
    test_degenerate();
    test_reset_mid();
    test_start_while_busy();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
